mips_instr_loader: RTL and testbench

Program loader for the single-cycle MIPS core: accepts symbolic instructions over a valid/ready stream and encodes them into 32-bit words. The words are written sequentially into instruction memory starting at a programmable base address. It is the writer side of the opcode map the main control unit decodes, so every word it emits uses exactly the opcodes the controller recognizes. It runs before the core is released from reset and signals completion and errors to the test harness.

---
 rtl/mips_instr_loader_if.sv | 29 ++
 rtl/mips_instr_loader.sv | 164 ++++++++++++++++
 tb/tb_mips_instr_loader.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_instr_loader_if.sv
// Symbolic-instruction stream into the loader plus the instruction-memory write bus it drives.
// master = program source / harness, slave = loader.
interface mips_instr_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [3:0]        op_sel;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, in_last, op_sel, rs, rt, rd, funct, imm, target,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_last, op_sel, rs, rt, rd, funct, imm, target,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/mips_instr_loader.sv
// Encodes symbolic MIPS instructions and writes them sequentially into instruction memory
// from a programmable base address, reporting completion and illegal-op / memory-full errors.
module mips_instr_loader #(
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 256,
    parameter int WR_WAIT = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base,
    mips_instr_loader_if.slave bus,
    output logic [ADDR_W:0]    count,
    output logic               busy,
    output logic               done,
    output logic [1:0]         err
);

    localparam int CW = ADDR_W + 1;
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_FULL    = 2'd2;

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, FIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic [CW-1:0]     count_q, count_d, count_inc;
    logic [1:0]        err_q, err_d;
    logic [2:0]        wait_q, wait_d;
    logic              last_q, last_d;
    logic              in_ready_q, in_ready_d;
    logic              imem_we_q, imem_we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [31:0]       enc_word;
    logic              op_legal;

    // Opcode is op_sel zero-extended, matching the control unit's decode table.
    always_comb begin
        enc_word = '0;
        op_legal = 1'b1;
        case (bus.op_sel)
            4'd0:                         enc_word = {6'd0, bus.rs, bus.rt, bus.rd, 5'd0, bus.funct};
            4'd1, 4'd2, 4'd3, 4'd4, 4'd8: enc_word = {2'b00, bus.op_sel, bus.rs, bus.rt, bus.imm};
            4'd5, 4'd6:                   enc_word = {2'b00, bus.op_sel, bus.target};
            4'd7:                         enc_word = {6'd7, bus.rs, 21'd0};
            default:                      op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        count_d      = count_q;
        err_d        = err_q;
        wait_d       = wait_q;
        last_d       = last_q;
        in_ready_d   = in_ready_q;
        imem_we_d    = imem_we_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        count_inc    = count_q + CW'(1);
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d     = base;
                    count_d    = '0;
                    err_d      = ERR_NONE;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                if (bus.in_valid && in_ready_q) begin
                    in_ready_d = 1'b0;
                    if (!op_legal) begin
                        err_d   = ERR_ILLEGAL;
                        done_d  = 1'b1;
                        state_d = FIN;
                    end else begin
                        imem_wdata_d = enc_word;
                        imem_addr_d  = addr_q;
                        last_d       = bus.in_last;
                        wait_d       = '0;
                        imem_we_d    = 1'b1;
                        state_d      = WRITE;
                    end
                end
            end
            WRITE: begin
                if (wait_q == 3'(WR_WAIT)) begin
                    imem_we_d = 1'b0;
                    count_d   = count_inc;
                    addr_d    = addr_q + ADDR_W'(1);
                    // A session-ending word wins over a full memory.
                    if (last_q) begin
                        done_d  = 1'b1;
                        state_d = FIN;
                    end else if (count_inc == CW'(DEPTH)) begin
                        err_d   = ERR_FULL;
                        done_d  = 1'b1;
                        state_d = FIN;
                    end else begin
                        in_ready_d = 1'b1;
                        state_d    = LOAD;
                    end
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            FIN: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            count_q      <= '0;
            err_q        <= ERR_NONE;
            wait_q       <= '0;
            last_q       <= 1'b0;
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            count_q      <= count_d;
            err_q        <= err_d;
            wait_q       <= wait_d;
            last_q       <= last_d;
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign count          = count_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_mips_instr_loader.sv
// Scoreboard bench: dut_a uses default parameters, dut_b uses DEPTH=4 / WR_WAIT=2.
// Stimulus pushes expected writes and done events; a negedge monitor pops and compares them.
module tb_mips_instr_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [7:0]  base = '0;
    logic        in_valid = 1'b0, in_last = 1'b0;
    logic [3:0]  op_sel = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0;
    logic [5:0]  funct = '0;
    logic [15:0] imm = '0;
    logic [25:0] target = '0;
    logic [8:0]  count_a, count_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic [1:0]  err_a, err_b;

    int cycle = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        bit          sel;
        logic [7:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    typedef struct {
        bit         sel;
        logic [8:0] cnt;
        logic [1:0] err;
        int         cyc;
    } done_t;

    wr_t   wr_q[$];
    done_t done_q[$];

    mips_instr_loader_if #(.ADDR_W(8)) if_a ();
    mips_instr_loader_if #(.ADDR_W(8)) if_b ();

    assign if_a.in_valid = in_valid;  assign if_b.in_valid = in_valid;
    assign if_a.in_last  = in_last;   assign if_b.in_last  = in_last;
    assign if_a.op_sel   = op_sel;    assign if_b.op_sel   = op_sel;
    assign if_a.rs       = rs;        assign if_b.rs       = rs;
    assign if_a.rt       = rt;        assign if_b.rt       = rt;
    assign if_a.rd       = rd;        assign if_b.rd       = rd;
    assign if_a.funct    = funct;     assign if_b.funct    = funct;
    assign if_a.imm      = imm;       assign if_b.imm      = imm;
    assign if_a.target   = target;    assign if_b.target   = target;

    mips_instr_loader #(.ADDR_W(8), .DEPTH(256), .WR_WAIT(0)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .base(base), .bus(if_a.slave),
        .count(count_a), .busy(busy_a), .done(done_a), .err(err_a)
    );

    mips_instr_loader #(.ADDR_W(8), .DEPTH(4), .WR_WAIT(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .base(base), .bus(if_b.slave),
        .count(count_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Per-DUT views for the monitor
    logic        we_s[2], done_s[2], busy_s[2];
    logic [7:0]  addr_s[2];
    logic [31:0] data_s[2];
    logic [8:0]  cnt_s[2];
    logic [1:0]  err_s[2];
    assign we_s[0] = if_a.imem_we;      assign we_s[1] = if_b.imem_we;
    assign addr_s[0] = if_a.imem_addr;  assign addr_s[1] = if_b.imem_addr;
    assign data_s[0] = if_a.imem_wdata; assign data_s[1] = if_b.imem_wdata;
    assign done_s[0] = done_a;          assign done_s[1] = done_b;
    assign busy_s[0] = busy_a;          assign busy_s[1] = busy_b;
    assign cnt_s[0] = count_a;          assign cnt_s[1] = count_b;
    assign err_s[0] = err_a;            assign err_s[1] = err_b;

    wr_t cur[2];
    int  we_len[2];
    bit  prev_we[2];
    bit  chk_idle[2];

    always @(negedge clk) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                prev_we[d] = 1'b0;
                we_len[d] = 0;
                chk_idle[d] = 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (we_s[d]) begin
                    if (!prev_we[d]) begin
                        we_len[d] = 0;
                        if (wr_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("[TB] FAIL unexpected_write: dut %0d addr 0x%0h data 0x%0h, expected none",
                                     d, addr_s[d], data_s[d]);
                            cur[d] = '{sel: d[0], addr: addr_s[d], data: data_s[d], cyc: cycle};
                        end else begin
                            cur[d] = wr_q.pop_front();
                            checkOutput("write_dut", 32'(d), 32'(cur[d].sel));
                            checkOutput("write_cycle", cycle, cur[d].cyc);
                        end
                    end
                    we_len[d]++;
                    checkOutput("write_addr", 32'(addr_s[d]), 32'(cur[d].addr));
                    checkOutput("write_data", data_s[d], cur[d].data);
                end else if (prev_we[d]) begin
                    checkOutput("we_length", we_len[d], (d == 1) ? 3 : 1);
                end
                prev_we[d] = we_s[d];

                if (chk_idle[d]) begin
                    checkOutput("busy_after_done", 32'(busy_s[d]), 32'd0);
                    chk_idle[d] = 1'b0;
                end
                if (done_s[d]) begin
                    if (done_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("[TB] FAIL unexpected_done: dut %0d count %0d err %0d, expected none",
                                 d, cnt_s[d], err_s[d]);
                    end else begin
                        done_t e;
                        e = done_q.pop_front();
                        checkOutput("done_dut", 32'(d), 32'(e.sel));
                        checkOutput("done_cycle", cycle, e.cyc);
                        checkOutput("done_count", 32'(cnt_s[d]), 32'(e.cnt));
                        checkOutput("done_err", 32'(err_s[d]), 32'(e.err));
                        checkOutput("busy_in_fin", 32'(busy_s[d]), 32'd1);
                    end
                    chk_idle[d] = 1'b1;
                end
            end
        end
    end

    // Called at posedge+1; leaves after the start edge, checking the t+1 outputs.
    task automatic startSession(input bit sel, input logic [7:0] b);
        base = b;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        checkOutput("start_busy", 32'(sel ? busy_b : busy_a), 32'd1);
        checkOutput("start_in_ready", 32'(sel ? if_b.in_ready : if_a.in_ready), 32'd1);
        checkOutput("start_err", 32'(sel ? err_b : err_a), 32'd0);
        checkOutput("start_count", 32'(sel ? count_b : count_a), 32'd0);
    endtask

    // Offers one instruction; returns the cycle number right after the accepting edge.
    task automatic applyStimulus(
        input bit sel, input logic [3:0] op, input logic [4:0] f_rs, input logic [4:0] f_rt,
        input logic [4:0] f_rd, input logic [5:0] f_funct, input logic [15:0] f_imm,
        input logic [25:0] f_target, input logic f_last,
        input bit exp_wr, input logic [7:0] exp_addr, input logic [31:0] exp_data,
        input bit exp_done, input logic [8:0] exp_cnt, input logic [1:0] exp_err,
        output int hs_cyc);
        bit acc = 1'b0;
        int waited = 0;
        int ww = sel ? 2 : 0;
        in_valid = 1'b1;
        op_sel = op; rs = f_rs; rt = f_rt; rd = f_rd;
        funct = f_funct; imm = f_imm; target = f_target; in_last = f_last;
        while (!acc && waited < 40) begin
            acc = sel ? if_b.in_ready : if_a.in_ready;
            @(posedge clk); #1;
            waited++;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        hs_cyc = cycle;
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL handshake_timeout: dut %0d op %0d not accepted within 40 cycles", sel, op);
        end else begin
            if (exp_wr) wr_q.push_back('{sel: sel, addr: exp_addr, data: exp_data, cyc: hs_cyc});
            if (exp_done)
                done_q.push_back('{sel: sel, cnt: exp_cnt, err: exp_err,
                                   cyc: exp_wr ? hs_cyc + 1 + ww : hs_cyc});
        end
    endtask

    task automatic waitIdle(input bit sel);
        int n = 0;
        while ((sel ? busy_b : busy_a) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("wait_idle", 32'(sel ? busy_b : busy_a), 32'd0);
    endtask

    logic [31:0] addi_words[4];
    int h0, h1;

    initial begin
        addi_words[0] = 32'h04010001;
        addi_words[1] = 32'h04020002;
        addi_words[2] = 32'h04030003;
        addi_words[3] = 32'h04040004;

        @(posedge clk); #1;
        checkOutput("rst_in_ready_a", 32'(if_a.in_ready), 32'd0);
        checkOutput("rst_we_a", 32'(if_a.imem_we), 32'd0);
        checkOutput("rst_addr_a", 32'(if_a.imem_addr), 32'd0);
        checkOutput("rst_wdata_a", if_a.imem_wdata, 32'd0);
        checkOutput("rst_count_a", 32'(count_a), 32'd0);
        checkOutput("rst_busy_a", 32'(busy_a), 32'd0);
        checkOutput("rst_done_a", 32'(done_a), 32'd0);
        checkOutput("rst_err_a", 32'(err_a), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] in_valid without start is ignored");
        in_valid = 1'b1; op_sel = 4'd1; imm = 16'h1234;
        for (int i = 0; i < 4; i++) begin
            checkOutput("nostart_ready_a", 32'(if_a.in_ready), 32'd0);
            checkOutput("nostart_ready_b", 32'(if_b.in_ready), 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;

        $display("[TB] single addi with in_last");
        startSession(1'b0, 8'h10);
        applyStimulus(0, 4'd1, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0005, 26'd0, 1'b1,
                      1, 8'h10, 32'h04220005, 1, 9'd1, 2'd0, h0);
        waitIdle(1'b0);
        checkOutput("count_hold_a", 32'(count_a), 32'd1);

        $display("[TB] R-type / lw / beq / j stream");
        startSession(1'b0, 8'h40);
        applyStimulus(0, 4'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0000, 26'd0, 1'b0,
                      1, 8'h40, 32'h00221820, 0, 9'd0, 2'd0, h0);
        applyStimulus(0, 4'd3, 5'd0, 5'd4, 5'd0, 6'd0, 16'h0008, 26'd0, 1'b0,
                      1, 8'h41, 32'h0C040008, 0, 9'd0, 2'd0, h1);
        checkOutput("throughput_a", h1 - h0, 32'd2);
        applyStimulus(0, 4'd8, 5'd1, 5'd2, 5'd0, 6'd0, 16'hFFFE, 26'd0, 1'b0,
                      1, 8'h42, 32'h2022FFFE, 0, 9'd0, 2'd0, h0);
        applyStimulus(0, 4'd5, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0000, 26'h40, 1'b1,
                      1, 8'h43, 32'h14000040, 1, 9'd4, 2'd0, h0);
        waitIdle(1'b0);

        $display("[TB] illegal op_sel after two good words");
        startSession(1'b0, 8'h00);
        applyStimulus(0, 4'd1, 5'd0, 5'd1, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b0,
                      1, 8'h00, 32'h0401FFFF, 0, 9'd0, 2'd0, h0);
        applyStimulus(0, 4'd2, 5'd3, 5'd4, 5'd0, 6'd0, 16'h0010, 26'd0, 1'b0,
                      1, 8'h01, 32'h08640010, 0, 9'd0, 2'd0, h0);
        applyStimulus(0, 4'd12, 5'd5, 5'd6, 5'd7, 6'd0, 16'h0001, 26'd0, 1'b0,
                      0, 8'h00, 32'h0, 1, 9'd2, 2'd1, h0);
        waitIdle(1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("err_held_a", 32'(err_a), 32'd1);

        $display("[TB] jr / jal");
        startSession(1'b0, 8'h80);
        applyStimulus(0, 4'd7, 5'd31, 5'd0, 5'd0, 6'd0, 16'h0000, 26'd0, 1'b0,
                      1, 8'h80, 32'h1FE00000, 0, 9'd0, 2'd0, h0);
        applyStimulus(0, 4'd6, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0000, 26'h3FFFFFF, 1'b1,
                      1, 8'h81, 32'h1BFFFFFF, 1, 9'd2, 2'd0, h0);
        waitIdle(1'b0);

        $display("[TB] DEPTH=4 full without in_last");
        startSession(1'b1, 8'h20);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 4'd1, 5'd0, 5'(k + 1), 5'd0, 6'd0, 16'(k + 1), 26'd0, 1'b0,
                          1, 8'h20 + 8'(k), addi_words[k], (k == 3), 9'd4, 2'd2, h1);
            if (k == 1) checkOutput("throughput_b", h1 - h0, 32'd4);
            h0 = h1;
        end
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checkOutput("full_ready_low", 32'(if_b.in_ready), 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        waitIdle(1'b1);
        checkOutput("full_err_held", 32'(err_b), 32'd2);

        $display("[TB] DEPTH=4 with in_last on word 4");
        startSession(1'b1, 8'h30);
        for (int k = 0; k < 4; k++)
            applyStimulus(1, 4'd1, 5'd0, 5'(k + 1), 5'd0, 6'd0, 16'(k + 1), 26'd0, (k == 3),
                          1, 8'h30 + 8'(k), addi_words[k], (k == 3), 9'd4, 2'd0, h0);
        waitIdle(1'b1);

        $display("[TB] WR_WAIT=2 address wrap and reset mid-write");
        startSession(1'b1, 8'hFF);
        applyStimulus(1, 4'd1, 5'd0, 5'd1, 5'd0, 6'd0, 16'h0001, 26'd0, 1'b0,
                      1, 8'hFF, addi_words[0], 0, 9'd0, 2'd0, h0);
        applyStimulus(1, 4'd1, 5'd0, 5'd2, 5'd0, 6'd0, 16'h0002, 26'd0, 1'b0,
                      1, 8'h00, addi_words[1], 0, 9'd0, 2'd0, h0);
        #10;
        checkOutput("we_before_rst", 32'(if_b.imem_we), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rstw_in_ready", 32'(if_b.in_ready), 32'd0);
        checkOutput("rstw_we", 32'(if_b.imem_we), 32'd0);
        checkOutput("rstw_addr", 32'(if_b.imem_addr), 32'd0);
        checkOutput("rstw_wdata", if_b.imem_wdata, 32'd0);
        checkOutput("rstw_count", 32'(count_b), 32'd0);
        checkOutput("rstw_busy", 32'(busy_b), 32'd0);
        checkOutput("rstw_done", 32'(done_b), 32'd0);
        checkOutput("rstw_err", 32'(err_b), 32'd0);
        @(negedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("post_rst_count", 32'(count_b), 32'd0);

        checkOutput("write_queue_empty", wr_q.size(), 32'd0);
        checkOutput("done_queue_empty", done_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
